// File: rtl/pwm_duty_sequencer_if.sv
// Request/step-pulse bundle between a duty-step requester and the sequencer.
// The master issues target steps; the slave (sequencer) drives the pulse
// outputs and status back.
interface pwm_duty_sequencer_if;
  logic       target_valid;
  logic [3:0] target_step;
  logic       target_ready;
  logic       increase_duty;
  logic       decrease_duty;
  logic [3:0] current_step;
  logic       busy;
  logic       done;
  logic       clamped;

  modport master (
    output target_valid,
    output target_step,
    input  target_ready,
    input  increase_duty,
    input  decrease_duty,
    input  current_step,
    input  busy,
    input  done,
    input  clamped
  );

  modport slave (
    input  target_valid,
    input  target_step,
    output target_ready,
    output increase_duty,
    output decrease_duty,
    output current_step,
    output busy,
    output done,
    output clamped
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// PWM duty-step sequencer: walks the applied duty step toward a requested
// target one step at a time, emitting a fixed-width increase/decrease pulse
// per step followed by a fixed quiet gap. All outputs come straight from
// registers so nothing on the request side reaches an output in the same
// cycle.
module pwm_duty_sequencer #(
  parameter int PULSE_CYCLES = 5,
  parameter int GAP_CYCLES   = 5,
  parameter int STEP_MAX     = 10,
  parameter int INIT_STEP    = 5
) (
  input logic                 clk,
  input logic                 rst,
  pwm_duty_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Pulse and gap lengths fit in an 8-bit counter (up to 255 cycles each).
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] STEP_TOP   = 4'(STEP_MAX);
  localparam logic [3:0] STEP_INIT  = 4'(INIT_STEP);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_target;
  logic [3:0] r_step;
  logic       r_inc;
  logic       r_dec;
  logic       r_done;
  logic       r_clamped;
  logic       r_ready;
  logic       r_busy;

  logic       w_over;
  logic [3:0] w_req_target;
  logic       w_accept;
  logic       w_pulse_end;
  logic       w_gap_end;

  // Requests above the top step are clamped to it before being latched.
  assign w_over       = (bus.target_step > STEP_TOP);
  assign w_req_target = w_over ? STEP_TOP : bus.target_step;

  // Acceptance only happens while ready, which is only true in IDLE.
  assign w_accept     = bus.target_valid & r_ready;

  assign w_pulse_end  = (r_cnt == PULSE_LAST);
  assign w_gap_end    = (r_cnt == GAP_LAST);

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_target  <= STEP_INIT;
      r_step    <= STEP_INIT;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_done    <= 1'b0;
      r_clamped <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      // Status strobes are single-cycle unless re-asserted below.
      r_done    <= 1'b0;
      r_clamped <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= 8'd0;
          if (w_accept) begin
            r_target  <= w_req_target;
            r_clamped <= w_over;
            if (w_req_target == r_step) begin
              // Already there: finish immediately without pulsing.
              r_done <= 1'b1;
            end else begin
              r_state <= PULSE;
              r_inc   <= (w_req_target > r_step);
              r_dec   <= (w_req_target < r_step);
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        PULSE: begin
          if (w_pulse_end) begin
            // The step is committed only when the full pulse has been given.
            r_cnt   <= 8'd0;
            r_state <= GAP;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            if (r_inc && (r_step < STEP_TOP)) begin
              r_step <= r_step + 4'd1;
            end else if (r_dec && (r_step != 4'd0)) begin
              r_step <= r_step - 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        GAP: begin
          if (w_gap_end) begin
            r_cnt <= 8'd0;
            if (r_step != r_target) begin
              r_state <= PULSE;
              r_inc   <= (r_target > r_step);
              r_dec   <= (r_target < r_step);
            end else begin
              // First IDLE cycle carries done and is already ready again.
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
          r_inc   <= 1'b0;
          r_dec   <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.target_ready  = r_ready;
  assign bus.busy          = r_busy;
  assign bus.increase_duty = r_inc;
  assign bus.decrease_duty = r_dec;
  assign bus.current_step  = r_step;
  assign bus.done          = r_done;
  assign bus.clamped       = r_clamped;

endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- PULSE_CYCLES, 5, cycles each increase_duty/decrease_duty pulse is held high (>=1)
- GAP_CYCLES, 5, cycles both step outputs are held low between pulses (>=1)
- STEP_MAX, 10, highest duty step (10 steps = 100%, 10% per step)
- INIT_STEP, 5, duty step after reset (50%), <= STEP_MAX
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state changes on rising edge
- rst, input, 1, synchronous active-high reset
- target_valid, input, 1, requested duty step is valid
- target_step, input, 4, requested duty step, 0..15
- target_ready, output, 1, block can accept a request
- increase_duty, output, 1, step-up pulse to the PWM generator
- decrease_duty, output, 1, step-down pulse to the PWM generator
- current_step, output, 4, duty step currently applied to the generator
- busy, output, 1, sequence in progress
- done, output, 1, one-cycle pulse when a request completes
- clamped, output, 1, one-cycle pulse when an accepted request exceeded STEP_MAX
REQ-003 All outputs SHALL be registered; no input SHALL reach an output combinationally.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, PULSE, and GAP.
REQ-005 target_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of target_ready.
REQ-006 A request SHALL be accepted on the edge where target_valid=1 and target_ready=1; target_step SHALL be ignored at all other times.
REQ-007 On acceptance, the latched target SHALL be min(target_step, STEP_MAX), and clamped SHALL pulse in the following cycle if target_step > STEP_MAX.
REQ-008 If the latched target equals current_step, the FSM SHALL remain in IDLE and done SHALL pulse in the following cycle; no step output SHALL toggle.
REQ-009 Otherwise IDLE SHALL go to PULSE, with direction up if target > current_step and down if target < current_step.
REQ-010 In PULSE, exactly one of increase_duty or decrease_duty SHALL be high, for exactly PULSE_CYCLES consecutive cycles, starting the cycle after acceptance.
REQ-011 current_step SHALL change by +1 or -1 on the edge that ends PULSE; the FSM SHALL then enter GAP.
REQ-012 In GAP, both step outputs SHALL be low for exactly GAP_CYCLES cycles.
REQ-013 At the end of GAP, the FSM SHALL return to PULSE if current_step differs from the target, and otherwise go to IDLE.
REQ-014 done SHALL be high for exactly one cycle, in the first IDLE cycle after completion; target_ready SHALL also be high in that cycle, so back-to-back requests are legal.
REQ-015 increase_duty and decrease_duty SHALL never be high in the same cycle.
REQ-016 current_step SHALL never leave 0..STEP_MAX; no wrap-around SHALL occur.
REQ-017 The cycles from acceptance to done SHALL be |target - start| * (PULSE_CYCLES + GAP_CYCLES) + 1, or 1 when target equals start.
REQ-018 The block SHALL support widths and counters for PULSE_CYCLES and GAP_CYCLES up to 255.

Reset
REQ-019 When rst=1 at an edge, the block SHALL enter IDLE and set current_step=INIT_STEP, increase_duty=0, decrease_duty=0, done=0, clamped=0, busy=0, target_ready=1.
REQ-020 Reset in the middle of a sequence SHALL abort it: no further pulses, no done, and no partial step is counted.
REQ-021 rst SHALL take priority over a simultaneous target_valid.

Verification
REQ-022 The bench SHALL cover these directed scenarios, using default parameters:
- Reset, then idle 20 cycles -> current_step=5, both step outputs 0, target_ready=1.
- Request target 8 from 5 -> three up pulses of 5 cycles with 5-cycle gaps; current_step goes 6, 7, 8; done 31 cycles after acceptance; decrease_duty stays 0.
- Request target 2 from 8 -> six down pulses; current_step reaches 2; done 61 cycles after acceptance.
- Request target 2 while at 2 -> done the next cycle, no pulses; then request 15 -> clamped pulses, sequence ends at 10, done.
- Hold target_valid=1 while busy with a changing target_step -> ignored until done; the value present in the done/ready cycle is accepted.
- Assert rst during the 3rd cycle of an up pulse -> next cycle outputs are 0, current_step=5, no done.
